// File: rtl/mole_game_ctrl_if.sv
// Player-guess inputs and display-facing outputs of the whack-a-mole game logic.
// The master side drives guesses; the slave side is mole_game_ctrl.
interface mole_game_ctrl_if;
  logic       guess_valid;
  logic [2:0] guess_pos;
  logic [2:0] mole_position;
  logic       guess_correct;
  logic       guess_wrong;
  logic [3:0] digit_1;
  logic [3:0] digit_2;

  modport master (
    output guess_valid,
    output guess_pos,
    input  mole_position,
    input  guess_correct,
    input  guess_wrong,
    input  digit_1,
    input  digit_2
  );

  modport slave (
    input  guess_valid,
    input  guess_pos,
    output mole_position,
    output guess_correct,
    output guess_wrong,
    output digit_1,
    output digit_2
  );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game logic: LFSR-driven mole placement, appearance timing,
// guess judgement with a timed feedback window, and a saturating BCD score.
module mole_game_ctrl #(
  parameter int unsigned MOLE_TIMEOUT    = 100000000,
  parameter int unsigned FEEDBACK_CYCLES = 50000000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic             master_clk,
  input  logic             rst,
  mole_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    SPAWN    = 2'd0,
    ACTIVE   = 2'd1,
    FEEDBACK = 2'd2
  } state_e;

  localparam logic [26:0] TIMEOUT_LAST  = 27'(MOLE_TIMEOUT - 1);
  localparam logic [26:0] FEEDBACK_LAST = 27'(FEEDBACK_CYCLES - 1);

  state_e      state_q,   state_d;
  logic [26:0] timer_q,   timer_d;
  logic [15:0] lfsr_q,    lfsr_d;
  logic [2:0]  mole_q,    mole_d;
  logic        correct_q, correct_d;
  logic        wrong_q,   wrong_d;
  logic [3:0]  tens_q,    tens_d;
  logic [3:0]  ones_q,    ones_d;
  logic [2:0]  cand;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mole_d    = mole_q;
    correct_d = correct_q;
    wrong_d   = wrong_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    cand      = lfsr_q[2:0];
    // Fibonacci taps 16,14,13,11 in right-shift form
    lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      SPAWN: begin
        mole_d  = (cand == mole_q) ? cand + 3'd1 : cand;
        timer_d = '0;
        state_d = ACTIVE;
      end

      ACTIVE: begin
        timer_d = timer_q + 27'd1;
        if (bus.guess_valid) begin
          timer_d = '0;
          state_d = FEEDBACK;
          if (bus.guess_pos == mole_q) begin
            correct_d = 1'b1;
            if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
              if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end
          end else begin
            wrong_d = 1'b1;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          wrong_d = 1'b1;
          state_d = FEEDBACK;
        end
      end

      FEEDBACK: begin
        if (timer_q == FEEDBACK_LAST) begin
          timer_d   = '0;
          correct_d = 1'b0;
          wrong_d   = 1'b0;
          state_d   = SPAWN;
        end else begin
          timer_d = timer_q + 27'd1;
        end
      end

      default: begin
        timer_d = '0;
        state_d = SPAWN;
      end
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      state_q   <= SPAWN;
      timer_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      mole_q    <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lfsr_q    <= lfsr_d;
      mole_q    <= mole_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign bus.mole_position = mole_q;
  assign bus.guess_correct = correct_q;
  assign bus.guess_wrong   = wrong_q;
  assign bus.digit_1       = tens_q;
  assign bus.digit_2       = ones_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed-plus-random bench for mole_game_ctrl with a round-level reference
// model (LFSR sequence, move rule, saturating score) kept in the bench.
module tb_mole_game_ctrl;
  localparam int unsigned T    = 20;
  localparam int unsigned FB   = 5;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int K_CORRECT = 0;
  localparam int K_WRONG   = 1;
  localparam int K_TIMEOUT = 2;

  logic master_clk = 1'b0;
  logic rst        = 1'b1;

  mole_game_ctrl_if gif();

  mole_game_ctrl #(
    .MOLE_TIMEOUT    (T),
    .FEEDBACK_CYCLES (FB),
    .LFSR_SEED       (SEED)
  ) dut (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (gif.slave)
  );

  always #5 master_clk = ~master_clk;

  int          n_pass    = 0;
  int          n_total   = 0;
  int          n_fail    = 0;
  logic [15:0] m_lfsr    = SEED;
  logic [2:0]  exp_mole  = '0;
  int          exp_score = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    // polynomial x^16 + x^14 + x^13 + x^11 + 1
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; the model follows the DUT's reset/LFSR behaviour.
  task automatic tick();
    @(posedge master_clk);
    if (rst) begin
      m_lfsr    = SEED;
      exp_mole  = '0;
      exp_score = 0;
    end else begin
      m_lfsr = lfsr_next(m_lfsr);
    end
    #1;
  endtask

  task automatic check_all(input string tag, input logic c, input logic w);
    chk({tag, ".mole"},    32'(gif.mole_position), 32'(exp_mole));
    chk({tag, ".correct"}, 32'(gif.guess_correct), 32'(c));
    chk({tag, ".wrong"},   32'(gif.guess_wrong),   32'(w));
    chk({tag, ".digit_1"}, 32'(gif.digit_1),       32'(exp_score / 10));
    chk({tag, ".digit_2"}, 32'(gif.digit_2),       32'(exp_score % 10));
  endtask

  // Called during the SPAWN cycle; ends in the first ACTIVE cycle.
  task automatic spawn(input bit strobe);
    logic [2:0] cand;
    logic [2:0] old;
    old  = exp_mole;
    cand = m_lfsr[2:0];
    exp_mole = (cand == exp_mole) ? 3'(cand + 3'd1) : cand;
    if (strobe) begin
      gif.guess_valid = 1'b1;
      gif.guess_pos   = exp_mole;
    end
    tick();
    gif.guess_valid = 1'b0;
    check_all("spawn", 1'b0, 1'b0);
    chk("spawn.moved", 32'(gif.mole_position != old), 32'd1);
  endtask

  // One full round from the first ACTIVE cycle to the next first ACTIVE cycle.
  task automatic round(input int kind, input int d, input bit strobe_fb, input bit strobe_spawn);
    int       early;
    logic [2:0] off;
    early = 0;
    if (kind == K_TIMEOUT) begin
      repeat (T - 1) begin
        tick();
        if (gif.guess_wrong || gif.guess_correct) early++;
      end
      chk("timeout.early", 32'(early), 32'd0);
      tick();
    end else begin
      repeat (d) begin
        tick();
        if (gif.guess_wrong || gif.guess_correct) early++;
      end
      chk("guess.early", 32'(early), 32'd0);
      off = 3'($urandom_range(1, 7));
      gif.guess_valid = 1'b1;
      gif.guess_pos   = (kind == K_CORRECT) ? exp_mole : 3'(exp_mole + off);
      tick();
      gif.guess_valid = 1'b0;
      gif.guess_pos   = 3'($urandom_range(0, 7));
      if (kind == K_CORRECT) exp_score = (exp_score >= 99) ? 99 : exp_score + 1;
    end
    check_all("judge", kind == K_CORRECT, kind != K_CORRECT);
    for (int i = 1; i < int'(FB); i++) begin
      if (strobe_fb && i == 1) begin
        gif.guess_valid = 1'b1;
        gif.guess_pos   = (kind == K_CORRECT) ? 3'(exp_mole + 3'd1) : exp_mole;
      end
      tick();
      gif.guess_valid = 1'b0;
      check_all("feedback", kind == K_CORRECT, kind != K_CORRECT);
    end
    tick();
    check_all("fb_end", 1'b0, 1'b0);
    spawn(strobe_spawn);
  endtask

  initial begin
    int kind;
    gif.guess_valid = 1'b0;
    gif.guess_pos   = '0;

    // Reset held for three edges
    rst = 1'b1;
    repeat (3) begin
      tick();
      check_all("reset", 1'b0, 1'b0);
    end
    rst = 1'b0;
    spawn(1'b0);
    chk("first_mole", 32'(gif.mole_position), 32'd1);

    // Directed rounds: hit, offset miss, timeout, guess on the timeout cycle
    round(K_CORRECT, int'($urandom_range(0, T - 2)), 1'b0, 1'b0);
    chk("hit1.digit_2", 32'(gif.digit_2), 32'd1);
    gif.guess_valid = 1'b1;
    gif.guess_pos   = 3'(exp_mole + 3'd3);
    tick();
    gif.guess_valid = 1'b0;
    check_all("miss3", 1'b0, 1'b1);
    for (int i = 1; i < int'(FB); i++) begin
      tick();
      check_all("miss3.fb", 1'b0, 1'b1);
    end
    tick();
    check_all("miss3.end", 1'b0, 1'b0);
    spawn(1'b0);
    round(K_TIMEOUT, 0, 1'b0, 1'b0);
    round(K_CORRECT, int'(T - 1), 1'b0, 1'b0);
    round(K_WRONG,   int'(T - 1), 1'b0, 1'b0);
    round(K_TIMEOUT, 0, 1'b1, 1'b1);

    // Random mix of outcomes and guess timing
    repeat (20) begin
      kind = int'($urandom_range(0, 2));
      round(kind, int'($urandom_range(0, T - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Climb to the saturation point, then hit once more at 99
    while (exp_score < 99)
      round(K_CORRECT, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    chk("sat.digit_1", 32'(gif.digit_1), 32'd9);
    chk("sat.digit_2", 32'(gif.digit_2), 32'd9);
    round(K_CORRECT, 1, 1'b1, 1'b1);
    chk("sat100.digit_2", 32'(gif.digit_2), 32'd9);

    // Reset arriving in the middle of a feedback window
    gif.guess_valid = 1'b1;
    gif.guess_pos   = exp_mole;
    tick();
    gif.guess_valid = 1'b0;
    check_all("pre_rst", 1'b1, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_all("mid_fb_rst", 1'b0, 1'b0);
    chk("mid_fb_rst.mole0", 32'(gif.mole_position), 32'd0);
    rst = 1'b0;
    spawn(1'b0);
    chk("post_rst_mole", 32'(gif.mole_position), 32'd1);
    round(K_CORRECT, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
